// File: rtl/lcd_pkg.sv
// lcd_pkg: HD44780 command bytes, sequencer/writer state codes and the init command table.
package lcd_pkg;
  localparam int CW = 20;
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON = 8'h0C;
  localparam logic [7:0] CMD_ENTRY = 8'h06;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_LINE1 = 8'h80;
  localparam logic [7:0] CMD_LINE2 = 8'hC0;
  localparam logic [2:0] S_PWR_WAIT = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_IDLE = 3'd2;
  localparam logic [2:0] S_LINE1 = 3'd3;
  localparam logic [2:0] S_FETCH = 3'd4;
  localparam logic [2:0] S_WRITE = 3'd5;
  localparam logic [2:0] S_LINE2 = 3'd6;
  localparam logic [2:0] S_FIN = 3'd7;
  localparam logic [1:0] P_IDLE = 2'd0;
  localparam logic [1:0] P_SETUP = 2'd1;
  localparam logic [1:0] P_EN = 2'd2;
  localparam logic [1:0] P_WAIT = 2'd3;
  function automatic logic [7:0] init_cmd(input logic [2:0] n);
    return n == 3'd2 ? CMD_DISP_ON : n == 3'd3 ? CMD_ENTRY : n == 3'd4 ? CMD_CLEAR : CMD_FUNC_SET;
  endfunction
endpackage

// File: rtl/lcd_byte_writer.sv
// lcd_byte_writer: one LCD byte transfer (setup, enable strobe, post-write wait) per accepted req.
module lcd_byte_writer
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned EN_CYC = 25,
  parameter int unsigned WAIT_CYC = 2500,
  parameter int unsigned CLEAR_WAIT_CYC = 100000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       ack,
  output logic       lcd_rs,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);
  logic [1:0] phase;
  logic [CW-1:0] cnt;
  logic [CW-1:0] last;
  logic long_q;
  always_comb begin
    last = phase == P_SETUP ? CW'(SETUP_CYC - 1) :
           phase == P_EN ? CW'(EN_CYC - 1) :
           long_q ? CW'(CLEAR_WAIT_CYC - 1) : CW'(WAIT_CYC - 1);
  end
  assign ack = phase == P_WAIT && cnt == last;
  assign lcd_en = phase == P_EN;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase <= P_IDLE;
      cnt <= '0;
      long_q <= 1'b0;
      lcd_rs <= 1'b0;
      lcd_data <= 8'h00;
    end else if (phase == P_IDLE) begin
      if (req) begin
        phase <= P_SETUP;
        cnt <= '0;
        lcd_rs <= rs;
        lcd_data <= data;
        long_q <= long_wait;
      end
    end else if (cnt == last) begin
      cnt <= '0;
      // SETUP -> EN -> WAIT -> IDLE is a plain increment that wraps
      phase <= phase + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/lcd_rom_sequencer.sv
// lcd_rom_sequencer: LCD power-up init, then copies a 32-byte ROM to both lines on each start.
module lcd_rom_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned POWERUP_CYC = 750000,
  parameter int unsigned SETUP_CYC = 4,
  parameter int unsigned EN_CYC = 25,
  parameter int unsigned WAIT_CYC = 2500,
  parameter int unsigned CLEAR_WAIT_CYC = 100000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [4:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_en,
  output logic [7:0] lcd_data
);
  logic [2:0] state;
  logic [2:0] step;
  logic [4:0] idx;
  logic [CW-1:0] cnt;
  logic sent, pending, init_done;
  logic req, ack, rs, long_wait;
  logic [7:0] data;
  // IDLE issues 0x80 in the same cycle start is seen so the bus updates on the next edge
  always_comb begin
    rs = state == S_WRITE;
    data = state == S_INIT ? init_cmd(step) :
           state == S_WRITE ? rom_data :
           state == S_LINE2 ? CMD_LINE2 : CMD_LINE1;
    req = state == S_IDLE ? (start || pending) && init_done :
          (state == S_INIT || state == S_WRITE || state == S_LINE2) && !sent;
    long_wait = !rs && data == CMD_CLEAR;
  end
  assign busy = state != S_IDLE;
  assign done = state == S_FIN;
  assign rom_addr = idx;
  assign lcd_rw = 1'b0;
  lcd_byte_writer #(
    .SETUP_CYC(SETUP_CYC),
    .EN_CYC(EN_CYC),
    .WAIT_CYC(WAIT_CYC),
    .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
  ) u_writer (
    .clock(clock),
    .reset_n(reset_n),
    .req(req),
    .rs(rs),
    .data(data),
    .long_wait(long_wait),
    .ack(ack),
    .lcd_rs(lcd_rs),
    .lcd_en(lcd_en),
    .lcd_data(lcd_data)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_PWR_WAIT;
      step <= '0;
      idx <= '0;
      cnt <= '0;
      sent <= 1'b0;
      pending <= 1'b0;
      init_done <= 1'b0;
    end else begin
      sent <= req ? 1'b1 : ack ? 1'b0 : sent;
      pending <= state != S_IDLE && (start || pending);
      case (state)
        S_PWR_WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(POWERUP_CYC - 1)) state <= S_INIT;
        end
        S_INIT: if (ack) begin
          step <= step + 3'd1;
          if (step == 3'd4) begin
            init_done <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_IDLE: if (req) state <= S_LINE1;
        S_LINE1: if (ack) begin
          idx <= 5'd0;
          state <= S_FETCH;
        end
        S_FETCH: state <= S_WRITE;
        S_WRITE: if (ack) begin
          if (idx == 5'd15) state <= S_LINE2;
          else if (idx == 5'd31) state <= S_FIN;
          else begin
            idx <= idx + 5'd1;
            state <= S_FETCH;
          end
        end
        S_LINE2: if (ack) begin
          idx <= 5'd16;
          state <= S_FETCH;
        end
        S_FIN: state <= S_IDLE;
        default: state <= S_PWR_WAIT;
      endcase
    end
  end
endmodule

// File: tb/tb_lcd_rom_sequencer.sv
// tb_lcd_rom_sequencer: directed scenarios for init, refresh, start collapsing and mid-run reset.
module tb_lcd_rom_sequencer;
  logic clock = 1'b0, reset_n = 1'b0, start = 1'b0;
  logic busy, done, lcd_rs, lcd_rw, lcd_en;
  logic [4:0] rom_addr;
  logic [7:0] rom_data = 8'h00, lcd_data;
  logic [7:0] rom [32];
  logic [255:0] txt;
  logic [7:0] exp_init [5] = '{8'h38, 8'h38, 8'h0C, 8'h06, 8'h01};
  int checks = 0, errors = 0, cyc = 0, rel = 0;
  logic rs_q[$];
  logic [7:0] data_q[$];
  int rise_q[$], fall_q[$];
  int tim_err = 0, done_cnt = 0, done_cyc = 0;
  int stable = 0, en_len = 0, low_after = 100;
  logic prev_en = 1'b0;
  logic [8:0] prev_val = '0;

  lcd_rom_sequencer #(
    .POWERUP_CYC(20), .SETUP_CYC(2), .EN_CYC(3), .WAIT_CYC(4), .CLEAR_WAIT_CYC(10)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_data(rom_data), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_en(lcd_en), .lcd_data(lcd_data)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(posedge clock) rom_data <= rom[rom_addr];

  // pin monitor: records every enable pulse and counts timing/rw violations
  always @(negedge clock) begin
    logic [8:0] val;
    val = {lcd_rs, lcd_data};
    if (!reset_n) begin
      prev_en = 1'b0; stable = 0; en_len = 0; low_after = 100; prev_val = val;
    end else begin
      if (val != prev_val) begin
        if (lcd_en || prev_en || low_after < 4) tim_err++;
        stable = 1;
      end else stable++;
      if (lcd_en && !prev_en) begin
        if (stable < 3) tim_err++;
        rs_q.push_back(lcd_rs); data_q.push_back(lcd_data); rise_q.push_back(cyc);
        en_len = 1;
      end else if (lcd_en) en_len++;
      if (!lcd_en && prev_en) begin
        if (en_len != 3) tim_err++;
        fall_q.push_back(cyc);
        low_after = 1;
      end else if (!lcd_en && low_after < 100) low_after++;
      if (lcd_rw !== 1'b0) tim_err++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      prev_en = lcd_en; prev_val = val;
    end
  end

  function automatic logic [8:0] exp_pulse(input int i);
    return i == 0 ? {1'b0, 8'h80} : i == 17 ? {1'b0, 8'hC0} :
           i < 17 ? {1'b1, rom[i-1]} : {1'b1, rom[i-2]};
  endfunction

  task automatic tick(); @(posedge clock); #1; endtask

  task automatic clear_mon();
    rs_q.delete(); data_q.delete(); rise_q.delete(); fall_q.delete();
    tim_err = 0; done_cnt = 0; done_cyc = 0;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    clear_mon();
    reset_n = 1'b1;
    rel = cyc;
  endtask

  task automatic pulse_start(); start = 1'b1; tick(); start = 1'b0; endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_busy got %b want 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (rom_addr !== 5'd0) begin errors++; $display("FAIL reset_addr got %h want 0", rom_addr); end
    checks++; if (lcd_rs !== 1'b0) begin errors++; $display("FAIL reset_rs got %b want 0", lcd_rs); end
    checks++; if (lcd_rw !== 1'b0) begin errors++; $display("FAIL reset_rw got %b want 0", lcd_rw); end
    checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", lcd_en); end
    checks++; if (lcd_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", lcd_data); end
  endtask

  task automatic test_init();
    int idle_cyc;
    apply_reset();
    for (int i = 0; i < 400 && busy; i++) tick();
    idle_cyc = cyc;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL init_timeout busy got %b want 0", busy); end
    checks++; if (rs_q.size() != 5) begin errors++; $display("FAIL init_count got %0d want 5", rs_q.size()); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rs_q[i], data_q[i]} !== {1'b0, exp_init[i]})
        begin errors++; $display("FAIL init_byte%0d got %h want %h", i, {rs_q[i], data_q[i]}, {1'b0, exp_init[i]}); end
    end
    checks++; if (rise_q[0] - rel != 23) begin errors++; $display("FAIL init_first_rise got %0d want 23", rise_q[0] - rel); end
    checks++; if (idle_cyc - fall_q[4] != 10) begin errors++; $display("FAIL clear_gap got %0d want 10", idle_cyc - fall_q[4]); end
    checks++; if (tim_err != 0) begin errors++; $display("FAIL init_timing got %0d want 0", tim_err); end
    repeat (30) tick();
    checks++; if (done_cnt != 0) begin errors++; $display("FAIL init_done_pulses got %0d want 0", done_cnt); end
    checks++; if (rs_q.size() != 5 || busy !== 1'b0)
      begin errors++; $display("FAIL init_quiet got %0d/%b want 5/0", rs_q.size(), busy); end
  endtask

  task automatic test_refresh();
    int s;
    clear_mon();
    s = cyc;
    pulse_start();
    checks++; if ({lcd_rs, lcd_data} !== 9'h080) begin errors++; $display("FAIL line1_latency got %h want 080", {lcd_rs, lcd_data}); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL refresh_busy got %b want 1", busy); end
    for (int i = 0; i < 1500 && done_cnt < 1; i++) tick();
    repeat (10) tick();
    checks++; if (rs_q.size() != 34) begin errors++; $display("FAIL refresh_count got %0d want 34", rs_q.size()); end
    for (int i = 0; i < 34; i++) begin
      checks++;
      if ({rs_q[i], data_q[i]} !== exp_pulse(i))
        begin errors++; $display("FAIL refresh_byte%0d got %h want %h", i, {rs_q[i], data_q[i]}, exp_pulse(i)); end
    end
    checks++; if (rise_q[0] - s != 3) begin errors++; $display("FAIL en_latency got %0d want 3", rise_q[0] - s); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL refresh_done got %0d want 1", done_cnt); end
    checks++; if (done_cyc - fall_q[33] != 4) begin errors++; $display("FAIL done_after_last got %0d want 4", done_cyc - fall_q[33]); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL refresh_idle got %b want 0", busy); end
    checks++; if (tim_err != 0) begin errors++; $display("FAIL refresh_timing got %0d want 0", tim_err); end
  endtask

  task automatic test_back_to_back();
    clear_mon();
    pulse_start();
    repeat (40) tick(); pulse_start();
    repeat (100) tick(); pulse_start();
    repeat (100) tick(); pulse_start();
    for (int i = 0; i < 2000 && done_cnt < 2; i++) tick();
    repeat (50) tick();
    checks++; if (rs_q.size() != 68) begin errors++; $display("FAIL b2b_count got %0d want 68", rs_q.size()); end
    checks++; if (done_cnt != 2) begin errors++; $display("FAIL b2b_done got %0d want 2", done_cnt); end
    checks++; if ({rs_q[34], data_q[34]} !== 9'h080) begin errors++; $display("FAIL b2b_line1 got %h want 080", {rs_q[34], data_q[34]}); end
    checks++; if ({rs_q[51], data_q[51]} !== 9'h0C0) begin errors++; $display("FAIL b2b_line2 got %h want 0c0", {rs_q[51], data_q[51]}); end
    checks++; if ({rs_q[67], data_q[67]} !== 9'h159) begin errors++; $display("FAIL b2b_last got %h want 159", {rs_q[67], data_q[67]}); end
    checks++; if (busy !== 1'b0 || tim_err != 0) begin errors++; $display("FAIL b2b_end got busy %b timing %0d want 0 0", busy, tim_err); end
  endtask

  task automatic test_start_in_pwr_wait();
    apply_reset();
    repeat (5) tick();
    pulse_start();
    for (int i = 0; i < 3000 && done_cnt < 1; i++) tick();
    repeat (20) tick();
    checks++; if (rs_q.size() != 39) begin errors++; $display("FAIL early_count got %0d want 39", rs_q.size()); end
    checks++; if ({rs_q[5], data_q[5]} !== 9'h080) begin errors++; $display("FAIL early_line1 got %h want 080", {rs_q[5], data_q[5]}); end
    checks++; if (rise_q[5] - fall_q[4] != 13) begin errors++; $display("FAIL early_gap got %0d want 13", rise_q[5] - fall_q[4]); end
    checks++; if ({rs_q[38], data_q[38]} !== 9'h159) begin errors++; $display("FAIL early_last got %h want 159", {rs_q[38], data_q[38]}); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL early_done got %0d want 1", done_cnt); end
    checks++; if (busy !== 1'b0 || tim_err != 0) begin errors++; $display("FAIL early_end got busy %b timing %0d want 0 0", busy, tim_err); end
  endtask

  task automatic test_reset_mid();
    clear_mon();
    pulse_start();
    for (int i = 0; i < 1500 && rise_q.size() < 22; i++) tick();
    checks++; if ({rs_q[21], data_q[21]} !== 9'h159) begin errors++; $display("FAIL mid_byte got %h want 159", {rs_q[21], data_q[21]}); end
    checks++; if (lcd_en !== 1'b1) begin errors++; $display("FAIL mid_en_before got %b want 1", lcd_en); end
    reset_n = 1'b0;
    #1;
    checks++; if (lcd_en !== 1'b0) begin errors++; $display("FAIL mid_en_async got %b want 0", lcd_en); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_async got %b want 1", busy); end
    checks++; if (lcd_data !== 8'h00 || rom_addr !== 5'd0)
      begin errors++; $display("FAIL mid_clear got %h/%h want 00/00", lcd_data, rom_addr); end
    repeat (2) tick();
    clear_mon();
    reset_n = 1'b1;
    rel = cyc;
    for (int i = 0; i < 400 && busy; i++) tick();
    repeat (10) tick();
    checks++; if (rs_q.size() != 5) begin errors++; $display("FAIL mid_reinit_count got %0d want 5", rs_q.size()); end
    checks++; if ({rs_q[0], data_q[0]} !== 9'h038) begin errors++; $display("FAIL mid_reinit_first got %h want 038", {rs_q[0], data_q[0]}); end
    checks++; if (rise_q[0] - rel != 23) begin errors++; $display("FAIL mid_powerup got %0d want 23", rise_q[0] - rel); end
    checks++; if (done_cnt != 0 || busy !== 1'b0)
      begin errors++; $display("FAIL mid_end got done %0d busy %b want 0 0", done_cnt, busy); end
  endtask

  initial begin
    txt = "DEFINIR PRINC:  P:XY  S:XY  A:XY";
    for (int i = 0; i < 32; i++) rom[i] = txt[255-8*i -: 8];
    test_reset();
    test_init();
    test_refresh();
    test_back_to_back();
    test_start_in_pwr_wait();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
